ltc2333_scan_sequencer: RTL

// Scan scheduler for the LTC2333 ADC write engine. Holds a programmable channel/SoftSpan table and

---
 rtl/ltc2333_scan_sequencer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/ltc2333_scan_sequencer.sv
// Scan scheduler for the LTC2333 write engine: walks a channel/SoftSpan table and issues one
// conversion request per entry over valid/ready, back-to-back or paced by a period counter.
module ltc2333_scan_sequencer #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 32,
  localparam int IDX_W = $clog2(N_CH),
  localparam int LEN_W = IDX_W + 1
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [CNT_W-1:0] period,
  input  logic [15:0]      n_scans,
  input  logic [LEN_W-1:0] seq_len,
  input  logic             tbl_we,
  input  logic [IDX_W-1:0] tbl_addr,
  input  logic [5:0]       tbl_wdata,
  output logic             conv_valid,
  input  logic             conv_ready,
  output logic [7:0]       conv_cfg,
  output logic [IDX_W-1:0] conv_idx,
  output logic             conv_first,
  output logic             busy,
  output logic [15:0]      scan_count,
  output logic             overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_TICK
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(N_CH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [5:0]       r_tbl [N_CH];
  logic [IDX_W-1:0] r_idx;
  logic [LEN_W-1:0] r_len;
  logic [15:0]      r_n_scans;
  logic             r_periodic;
  logic [CNT_W-1:0] r_period_m1;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_scan_count;
  logic             r_overrun;
  logic             r_stop_pending;
  logic [7:0]       r_cfg;
  logic             r_first;

  logic [LEN_W-1:0] w_len_clamped;
  logic [CNT_W-1:0] w_period_m1;
  logic             w_hs;
  logic             w_last;
  logic             w_stop_req;
  logic             w_stop_eff;
  logic             w_quota_done;
  logic             w_tick;
  logic             w_start_acc;
  logic             w_scan_done;
  logic             w_load;
  logic [IDX_W-1:0] w_load_idx;

  always_comb begin
    if (seq_len == '0)          w_len_clamped = LEN_W'(1);
    else if (seq_len > MAX_LEN) w_len_clamped = MAX_LEN;
    else                        w_len_clamped = seq_len;
  end

  assign w_period_m1  = (period < CNT_W'(2)) ? CNT_W'(1) : period - CNT_W'(1);
  assign w_hs         = (r_state == S_ISSUE) && conv_ready;
  assign w_last       = (LEN_W'(r_idx) == r_len - LEN_W'(1));
  assign w_stop_req   = stop || !enable;
  assign w_stop_eff   = w_stop_req || r_stop_pending;
  assign w_quota_done = (r_n_scans != 16'd0) &&
                        (({1'b0, r_scan_count} + 17'd1) == {1'b0, r_n_scans});
  assign w_tick       = (r_state != S_IDLE) && (r_cnt == '0);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_scan_done = 1'b0;
    w_load      = 1'b0;
    w_load_idx  = '0;
    case (r_state)
      S_IDLE: begin
        if (start && enable && !stop) begin
          w_state_nxt = S_ISSUE;
          w_start_acc = 1'b1;
          w_load      = 1'b1;
        end
      end
      S_ISSUE: begin
        if (w_hs) begin
          if (w_last) begin
            w_scan_done = 1'b1;
            if (w_stop_eff || w_quota_done) begin
              w_state_nxt = S_IDLE;
            end else if (!r_periodic) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = S_WAIT_TICK;
            end
          end else if (w_stop_eff) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_load     = 1'b1;
            w_load_idx = r_idx + IDX_W'(1);
          end
        end
      end
      S_WAIT_TICK: begin
        if (w_stop_req) begin
          w_state_nxt = S_IDLE;
        end else if (w_tick) begin
          w_state_nxt = S_ISSUE;
          w_load      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: the table is small and must read back as zero after reset, so it is built from resettable flops.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < N_CH; i++) r_tbl[i] <= 6'h00;
    end else if (tbl_we) begin
      r_tbl[tbl_addr] <= tbl_wdata;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_idx          <= '0;
      r_len          <= LEN_W'(1);
      r_n_scans      <= '0;
      r_periodic     <= 1'b0;
      r_period_m1    <= CNT_W'(1);
      r_cnt          <= '0;
      r_scan_count   <= '0;
      r_overrun      <= 1'b0;
      r_stop_pending <= 1'b0;
      r_cfg          <= '0;
      r_first        <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_len       <= w_len_clamped;
        r_n_scans   <= n_scans;
        r_periodic  <= periodic;
        r_period_m1 <= w_period_m1;
      end

      // Load reads the table before any same-cycle write lands, so the old entry is issued.
      if (w_load) begin
        r_idx   <= w_load_idx;
        r_cfg   <= {2'b10, r_tbl[w_load_idx]};
        r_first <= (w_load_idx == '0);
      end else if (w_scan_done) begin
        r_idx <= '0;
      end

      if (w_start_acc) begin
        r_cnt <= w_period_m1;
      end else if (r_state != S_IDLE) begin
        r_cnt <= (r_cnt == '0) ? r_period_m1 : r_cnt - CNT_W'(1);
      end

      if (w_start_acc) begin
        r_scan_count <= '0;
      end else if (w_scan_done && (r_scan_count != 16'hFFFF)) begin
        r_scan_count <= r_scan_count + 16'd1;
      end

      // A tick that lands while a periodic scan is still issuing is lost and flagged.
      if (w_start_acc) begin
        r_overrun <= 1'b0;
      end else if ((r_state == S_ISSUE) && r_periodic && w_tick) begin
        r_overrun <= 1'b1;
      end

      r_stop_pending <= (r_state == S_ISSUE) && (w_state_nxt == S_ISSUE) && w_stop_eff;
    end
  end

  assign conv_valid = (r_state == S_ISSUE);
  assign busy       = (r_state != S_IDLE);
  assign conv_cfg   = r_cfg;
  assign conv_idx   = r_idx;
  assign conv_first = r_first;
  assign scan_count = r_scan_count;
  assign overrun    = r_overrun;

endmodule
